// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Multi-cycle data memory for the MEM-stage load/store port. A request seen
// while idle is latched and the pipeline is held through Stall for LATENCY
// cycles. The access then completes: stores commit at the closing edge of the
// completion cycle, and loads return data combinationally during it.
//
// Parameters
//   LATENCY    wait cycles per access (1..15)
//   ADDR_BITS  word-index width; memory holds 2**ADDR_BITS 32-bit words
//
// Ports
//   Clk        rising-edge clock
//   Reset      synchronous, active-high reset (memory contents are kept)
//   Address    byte address; word index is Address[ADDR_BITS+1:2]
//   WriteData  store data
//   MemWrite   store request
//   MemRead    load request (write wins when both are high)
//   Size       00 word, 01 half, 10 byte, 11 word
//   Unsigned   1 zero-extends sub-word loads, 0 sign-extends them
//   ReadData   load result, non-zero only in the completion cycle
//   Stall      holds the upstream pipeline while high
//   Err        one-cycle pulse in the completion cycle of a misaligned access
//
// Build option
//   DM_BYTE_LANES_EN  when defined, enables sub-word lanes, extension and
//                     misalignment checking. When undefined every access is a
//                     full word, Size/Unsigned/Address[1:0] are ignored and
//                     Err stays 0.
// -----------------------------------------------------------------------------
module data_mem_responder #(
   parameter int LATENCY   = 2,
   parameter int ADDR_BITS = 10
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic [1:0]  Size,
   input  logic        Unsigned,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        Err
);

   localparam int DEPTH = 1 << ADDR_BITS;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q,   cnt_d;
   logic [31:0] addr_q,  addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [1:0]  size_q,  size_d;
   logic        uns_q,   uns_d;
   logic        wr_q,    wr_d;

   logic [31:0] mem_q [DEPTH] = '{default: '0};

   logic                 req;
   logic                 done;
   logic                 misalign;
   logic                 wr_commit;
   logic [ADDR_BITS-1:0] widx;
   logic [31:0]          rd_word;
   logic [31:0]          rd_data;
   logic [31:0]          wr_word;
   logic                 unused_bits;

`ifdef DM_BYTE_LANES_EN
   // Half must be 2-byte aligned, word (and the 11 encoding) 4-byte aligned.
   function automatic logic is_misaligned(input logic [1:0] size,
                                          input logic [1:0] ofs);
      case (size)
         2'b01:   is_misaligned = ofs[0];
         2'b10:   is_misaligned = 1'b0;
         default: is_misaligned = (ofs != 2'b00);
      endcase
   endfunction

   // Select the addressed lane and sign/zero extend it.
   function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                input logic [1:0]  ofs,
                                                input logic [1:0]  size,
                                                input logic        uns);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{ofs, 3'b000} +: 8];
      h = word[{ofs[1], 4'b0000} +: 16];
      case (size)
         2'b10:   load_extract = {{24{~uns & b[7]}}, b};
         2'b01:   load_extract = {{16{~uns & h[15]}}, h};
         default: load_extract = word;
      endcase
   endfunction

   // Replace only the addressed lane of the current word with store data.
   function automatic logic [31:0] store_merge(input logic [31:0] word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  ofs,
                                               input logic [1:0]  size);
      logic [31:0] r;
      r = word;
      case (size)
         2'b10:   r[{ofs, 3'b000} +: 8]     = wdata[7:0];
         2'b01:   r[{ofs[1], 4'b0000} +: 16] = wdata[15:0];
         default: r = wdata;
      endcase
      store_merge = r;
   endfunction
`endif

   assign req  = MemRead | MemWrite;
   assign widx = addr_q[ADDR_BITS+1:2];

   // State register and request latches
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         wr_q    <= wr_d;
      end
   end

   // Store port; wr_commit already excludes cycles with Reset high
   always_ff @(posedge Clk) begin
      if (wr_commit) begin
         mem_q[widx] <= wr_word;
      end
   end

   // Next state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      size_d  = size_q;
      uns_d   = uns_q;
      wr_d    = wr_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               state_d = BUSY;
               cnt_d   = CNT_INIT;
               addr_d  = Address;
               wdata_d = WriteData;
               size_d  = Size;
               uns_d   = Unsigned;
               wr_d    = MemWrite;
            end
         end
         BUSY: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Lane handling on the latched request
   always_comb begin
      rd_word = mem_q[widx];
`ifdef DM_BYTE_LANES_EN
      misalign    = is_misaligned(size_q, addr_q[1:0]);
      rd_data     = load_extract(rd_word, addr_q[1:0], size_q, uns_q);
      wr_word     = store_merge(rd_word, wdata_q, addr_q[1:0], size_q);
      unused_bits = ^addr_q[31:ADDR_BITS+2];
`else
      misalign    = 1'b0;
      rd_data     = rd_word;
      wr_word     = wdata_q;
      unused_bits = ^{addr_q[31:ADDR_BITS+2], addr_q[1:0], size_q, uns_q};
`endif
   end

   // Outputs; everything is forced quiet while Reset is high
   always_comb begin
      done      = ~Reset & (state_q == BUSY) & (cnt_q == 4'd0);
      Stall     = ~Reset & (((state_q == IDLE) & req) |
                            ((state_q == BUSY) & (cnt_q != 4'd0)));
      wr_commit = done & wr_q & ~misalign;
      Err       = done & misalign;
      ReadData  = (done & ~wr_q & ~misalign) ? rd_data : 32'h0;
   end

endmodule
